// File: rtl/add_arb_pkg.sv
// rtl/add_arb_pkg.sv - shared widths, defaults and issue-FSM state type for add_arbiter
package add_arb_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int VEC_LEN        = 3;
    localparam int NUM_REQ_DFLT   = 4;
    localparam int TAG_DEPTH_DFLT = 8;

    typedef logic signed [DATA_WIDTH-1:0] word_t;
    typedef word_t [VEC_LEN-1:0] vec_t;

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/add_arbiter_if.sv
// rtl/add_arbiter_if.sv - operand/result handshake between the arbiter and the shared add unit
interface add_arbiter_if import add_arb_pkg::*;;

    vec_t add_x;
    vec_t add_y;
    logic add_in_empty;
    logic add_in_rd_en;
    vec_t add_out;
    logic add_out_empty;
    logic add_out_rd_en;

    modport master (
        output add_x, add_y, add_in_empty, add_out_rd_en,
        input  add_in_rd_en, add_out, add_out_empty
    );

    modport slave (
        input  add_x, add_y, add_in_empty, add_out_rd_en,
        output add_in_rd_en, add_out, add_out_empty
    );

endinterface

// File: rtl/add_arbiter_tag_fifo.sv
// rtl/add_arbiter_tag_fifo.sv - first-word-fall-through FIFO of requester tags awaiting results
module tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && (count_q != (AW+1)'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/add_arbiter.sv
// rtl/add_arbiter.sv - round-robin sharing of one vector add unit, in-order result return by tag
module add_arbiter import add_arb_pkg::*; #(
    parameter int NUM_REQ   = NUM_REQ_DFLT,
    parameter int TAG_DEPTH = TAG_DEPTH_DFLT
) (
    input  logic                clock,
    input  logic                reset,
    input  vec_t [NUM_REQ-1:0]  req_x,
    input  vec_t [NUM_REQ-1:0]  req_y,
    input  logic [NUM_REQ-1:0]  req_empty,
    output logic [NUM_REQ-1:0]  req_rd_en,
    output vec_t [NUM_REQ-1:0]  rsp_out,
    input  logic [NUM_REQ-1:0]  rsp_full,
    output logic [NUM_REQ-1:0]  rsp_wr_en,
    add_arbiter_if.master       add_bus
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TAG_DEPTH) + 1;

    state_e          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]   pick;
    logic            pick_valid;
    logic            tags_ok;
    logic            issue;
    logic            tag_pop;
    logic            tag_empty;
    logic [GW-1:0]   tag_head;
    logic [CW-1:0]   tag_count;

    // Scan downward so the index closest to rr_ptr is the last one written.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            automatic int idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!req_empty[idx]) begin
                pick       = GW'(idx);
                pick_valid = 1'b1;
            end
        end
    end

    assign tags_ok = int'(tag_count) < TAG_DEPTH;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ARB;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ARB: begin
                if (pick_valid && tags_ok) begin
                    grant_d = pick;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (add_bus.add_in_rd_en) begin
                    rr_ptr_d = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                    state_d  = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_comb begin
        issue                = (state_q == HOLD) && add_bus.add_in_rd_en;
        add_bus.add_in_empty = (state_q != HOLD);
        add_bus.add_x        = req_x[grant_q];
        add_bus.add_y        = req_y[grant_q];
        req_rd_en            = '0;
        if (issue) begin
            req_rd_en[grant_q] = 1'b1;
        end
    end

    // Return path is independent of the issue FSM; the tag head owns the next result.
    always_comb begin
        tag_pop               = !add_bus.add_out_empty && !tag_empty && !rsp_full[tag_head];
        add_bus.add_out_rd_en = tag_pop;
        rsp_wr_en             = '0;
        if (tag_pop) begin
            rsp_wr_en[tag_head] = 1'b1;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_out[i] = add_bus.add_out;
        end
    end

    tag_fifo #(
        .WIDTH (GW),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (issue),
        .data_i  (grant_q),
        .pop_i   (tag_pop),
        .data_o  (tag_head),
        .empty_o (tag_empty),
        .count_o (tag_count)
    );

endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 Parameter: NUM_REQ, 4, number of requesters sharing one vector add unit.
REQ-002 Parameter: TAG_DEPTH, 8, maximum operations outstanding in the add unit; power of two.
REQ-003 Port: clock  in  1  sole clock; all state updates on rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-low reset.
REQ-005 Port: req_x  in  NUM_REQ x 3 x 32 signed  per-requester operand x (first-word-fall-through FIFO head).
REQ-006 Port: req_y  in  NUM_REQ x 3 x 32 signed  per-requester operand y.
REQ-007 Port: req_empty  in  NUM_REQ  per-requester operand FIFO empty.
REQ-008 Port: req_rd_en  out  NUM_REQ  per-requester operand pop.
REQ-009 Port: rsp_out  out  NUM_REQ x 3 x 32 signed  per-requester result data.
REQ-010 Port: rsp_full  in  NUM_REQ  per-requester result FIFO full.
REQ-011 Port: rsp_wr_en  out  NUM_REQ  per-requester result push.
REQ-012 Port: add_x, add_y  out  3 x 32 signed each  operands to add unit.
REQ-013 Port: add_in_empty  out  1  low when operands are presented to add unit.
REQ-014 Port: add_in_rd_en  in  1  add unit consumes presented operands.
REQ-015 Port: add_out  in  3 x 32 signed  add unit result FIFO head (first-word-fall-through).
REQ-016 Port: add_out_empty  in  1  add unit result FIFO empty.
REQ-017 Port: add_out_rd_en  out  1  pop add unit result.

Function
REQ-018 Issue FSM SHALL have states ARB and HOLD; registers grant (log2 NUM_REQ bits) and rr_ptr.
REQ-019 In ARB, if any req_empty[i]=0 and tag count < TAG_DEPTH, grant SHALL load the first non-empty index searching upward from rr_ptr with wrap, and state SHALL go to HOLD; else stay in ARB.
REQ-020 In ARB, add_in_empty SHALL be 1 and all req_rd_en SHALL be 0.
REQ-021 In HOLD, add_x/add_y SHALL equal req_x/req_y[grant] and add_in_empty SHALL be 0.
REQ-022 In HOLD, when add_in_rd_en=1: req_rd_en[grant]=1 in the same cycle, grant pushed to tag FIFO, rr_ptr <= (grant+1) mod NUM_REQ, state -> ARB.
REQ-023 Issue rate SHALL be at most one operation per two cycles; grant SHALL NOT change while in HOLD.
REQ-024 Return path (combinational, independent of FSM): when add_out_empty=0, tag FIFO non-empty and rsp_full[tag_head]=0, add_out_rd_en=1, rsp_wr_en[tag_head]=1, tag FIFO popped; otherwise all 0.
REQ-025 rsp_out[i] SHALL equal add_out for every i; only rsp_wr_en qualifies data.
REQ-026 Results SHALL return to requesters in issue order; no reordering; a full destination stalls all returns (head-of-line).
REQ-027 Simultaneous tag push and pop SHALL leave tag count unchanged; count SHALL never exceed TAG_DEPTH nor underflow.
REQ-028 add_out_empty=0 with tag FIFO empty SHALL produce no pop (protocol error; result held).
REQ-029 Arithmetic is performed by the add unit; this block SHALL pass data unmodified, 32-bit signed, no width change.

Reset
REQ-030 On reset=0: state=ARB, grant=0, rr_ptr=0, tag FIFO empty; req_rd_en, rsp_wr_en, add_out_rd_en =0; add_in_empty=1; add_x/add_y/rsp_out follow combinational sources.
REQ-031 Reset mid-operation SHALL discard outstanding tags; the add unit SHALL share the same reset so no orphan results remain.

Structure
REQ-032 Package add_arb_pkg SHALL hold DATA_WIDTH=32, VEC_LEN=3, default NUM_REQ/TAG_DEPTH, and the ARB/HOLD state typedef.
REQ-033 Sub-module tag_fifo SHALL implement the tag store: synchronous, width log2 NUM_REQ, depth TAG_DEPTH, first-word-fall-through, with count output.

Verification
REQ-034 Single op: req 2 x=(1,2,3), y=(10,-20,30) -> rsp_wr_en[2] once, rsp_out=(11,-18,33), other rsp_wr_en 0.
REQ-035 All four requesters non-empty continuously, rr_ptr=0 -> grant order 0,1,2,3,0, each granted exactly once per 4 issues.
REQ-036 Add result FIFO never drained (hold rsp_full[0]=1), req 0 streaming -> exactly 8 issues, then add_in_empty stays 1.
REQ-037 Issue req 1 then req 3, rsp_full[1]=1 for 20 cycles -> no rsp_wr_en to 3 until req 1 written; order 1 then 3.
REQ-038 Overflow: x=(0x7FFFFFFF,0,0), y=(1,0,0) -> rsp_out=(0x80000000,0,0) unmodified wrap.
REQ-039 Assert reset low in HOLD with 3 tags outstanding -> next cycle state ARB, tag count 0, all enables 0.
